// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed eight-digit seven-segment scanner.
// Segment patterns are active-low in abcdefg order, index = hex value.
package ssd_scan_ctrl_pkg;

    localparam int NUM_DIGITS           = 8;
    localparam int DEFAULT_DIGIT_CYCLES = 262144;
    localparam int DEFAULT_BLANK_CYCLES = 1024;

    localparam logic [7:0] BLANK_PATTERN = 8'hFF;

    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // D
        7'b0110001,  // C
        7'b1100000,  // B
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] hex;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
    } disp_set_t;

endpackage

// File: rtl/ssd_scan_ctrl_hex_to_seg.sv
// Hex nibble to active-low abcdefg segment pattern.
// Latency: purely combinational.
// Backpressure: none.
module hex_to_seg
    import ssd_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan of eight seven-segment digits with per-slot anti-ghost blanking.
// Latency: outputs registered from next-cycle state, so they match the current slot/phase.
// Backpressure: upd_ready drops on accept and returns only after the frame-boundary commit.
module ssd_scan_ctrl
    import ssd_scan_ctrl_pkg::*;
#(
    parameter int DIGIT_CYCLES = DEFAULT_DIGIT_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_hex,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    input  logic [NUM_DIGITS-1:0]   upd_en,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [7:0]              cathodes,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    disp_set_t        active;
    disp_set_t        active_nxt;
    disp_set_t        shadow;
    logic             pending;
    logic             end_of_frame;
    logic             accept;
    phase_t           phase_nxt;
    logic [3:0]       nib_nxt;
    logic [6:0]       seg_nxt;

    // Everything is evaluated for the cycle about to start, so the registered
    // outputs line up with the slot counter instead of trailing it.
    always_comb begin
        end_of_frame = (cnt == CNT_LAST) && (idx == IDX_LAST);
        accept       = upd_valid && upd_ready;
        cnt_nxt      = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        idx_nxt      = (cnt == CNT_LAST) ? idx + 1'b1 : idx;
        active_nxt   = (end_of_frame && pending) ? shadow : active;
        phase_nxt    = (cnt_nxt < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
        nib_nxt      = active_nxt.hex[{idx_nxt, 2'b00} +: 4];
    end

    hex_to_seg u_hex_to_seg (
        .hex (nib_nxt),
        .seg (seg_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            upd_ready  <= 1'b1;
            frame_done <= 1'b0;
            anodes     <= BLANK_PATTERN;
            cathodes   <= BLANK_PATTERN;
        end else begin
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            active <= active_nxt;

            // Accept needs ready, ready needs !pending, so accept and commit are exclusive.
            if (accept) begin
                shadow    <= '{hex: upd_hex, dp: upd_dp, en: upd_en};
                pending   <= 1'b1;
                upd_ready <= 1'b0;
            end else if (end_of_frame && pending) begin
                pending   <= 1'b0;
                upd_ready <= 1'b1;
            end

            frame_done <= (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);

            if (phase_nxt == PH_DRIVE && active_nxt.en[idx_nxt]) begin
                anodes   <= ~(NUM_DIGITS'(1) << idx_nxt);
                cathodes <= {seg_nxt, ~active_nxt.dp[idx_nxt]};
            end else begin
                anodes   <= BLANK_PATTERN;
                cathodes <= BLANK_PATTERN;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed scoreboard bench for ssd_scan_ctrl with 16-cycle slots and 4-cycle blanking.
module tb_ssd_scan_ctrl;

    localparam int DC    = 16;
    localparam int BC    = 4;
    localparam int FRAME = 8 * DC;
    localparam int BIG   = 1000000;

    typedef logic [7:0][7:0] cat_t;

    typedef struct {
        int         lo;
        int         hi;
        logic [7:0] an;
        logic [7:0] ca;
        logic       rdy;
        string      tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_hex;
    logic [7:0]  upd_dp;
    logic [7:0]  upd_en;
    logic [7:0]  anodes;
    logic [7:0]  cathodes;
    logic        frame_done;

    int   pos;
    int   n_chk;
    int   n_fail;
    exp_t q[$];
    cat_t cat_a, cat_b, cat_c, cat_d;

    ssd_scan_ctrl #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_hex    (upd_hex),
        .upd_dp     (upd_dp),
        .upd_en     (upd_en),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle position since reset release; equals the scan position of the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) pos <= 0;
        else       pos <= pos + 1;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at pos %0d: got %0h expected %0h", name, pos, act, exp);
        end
    endtask

    task automatic push(int lo, int hi, logic [7:0] an, logic [7:0] ca, int ru, string tag);
        exp_t e;
        e.an  = an;
        e.ca  = ca;
        e.tag = tag;
        if (hi <= ru || lo > ru) begin
            e.lo = lo; e.hi = hi; e.rdy = (hi <= ru);
            q.push_back(e);
        end else begin
            e.lo = lo;     e.hi = ru; e.rdy = 1'b1;
            q.push_back(e);
            e.lo = ru + 1; e.hi = hi; e.rdy = 1'b0;
            q.push_back(e);
        end
    endtask

    // upd_ready expected high for pos <= ru; items clipped at stop.
    task automatic expect_frame(int base, logic [7:0] en, cat_t cat, int ru, int stop, string tag);
        for (int k = 0; k < 8; k++) begin
            int         b;
            int         h;
            logic [7:0] an;
            b  = base + k * DC;
            an = 8'h01 << k;
            an = ~an;
            if (b <= stop) begin
                h = (b + BC - 1 > stop) ? stop : b + BC - 1;
                push(b, h, 8'hFF, 8'hFF, ru, $sformatf("%s_d%0d_blank", tag, k));
            end
            if (b + BC <= stop) begin
                h = (b + DC - 1 > stop) ? stop : b + DC - 1;
                if (en[k]) push(b + BC, h, an, cat[k], ru, $sformatf("%s_d%0d_drive", tag, k));
                else       push(b + BC, h, 8'hFF, 8'hFF, ru, $sformatf("%s_d%0d_off", tag, k));
            end
        end
    endtask

    task automatic send(int at, logic [31:0] h, logic [7:0] d, logic [7:0] e);
        while (pos != at) @(negedge clk);
        upd_hex   = h;
        upd_dp    = d;
        upd_en    = e;
        upd_valid = 1'b1;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("frame_done", 32'(frame_done), 32'((pos % FRAME) == FRAME - 1));
            chk("single_anode", 32'($countones(~anodes) <= 1), 32'd1);
            while (q.size() > 0 && q[0].hi < pos) begin
                chk($sformatf("%s_missed", q[0].tag), 32'(q[0].hi), 32'(pos));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].lo <= pos) begin
                chk($sformatf("%s_an", q[0].tag), 32'(anodes), 32'(q[0].an));
                chk($sformatf("%s_ca", q[0].tag), 32'(cathodes), 32'(q[0].ca));
                chk($sformatf("%s_rdy", q[0].tag), 32'(upd_ready), 32'(q[0].rdy));
                if (q[0].hi == pos) void'(q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        upd_valid = 1'b0;
        upd_hex   = '0;
        upd_dp    = '0;
        upd_en    = '0;
        // Hand-decoded cathode bytes {abcdefg, Dp}, digit 7 first.
        cat_a = {8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h02};  // 76543210, dp=01
        cat_b = {8'h70, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01};  // FEDCBA98, dp=80
        cat_c = {8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03};  // 76543210, dp=00
        cat_d = {8'h1E, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03};  // 76543210, dp=80

        repeat (2) @(posedge clk);
        #3;
        chk("reset_anodes", 32'(anodes), 32'hFF);
        chk("reset_cathodes", 32'(cathodes), 32'hFF);
        chk("reset_ready", 32'(upd_ready), 32'd1);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        expect_frame(0,   8'h00, cat_a, 200, BIG, "idle0");
        expect_frame(128, 8'h00, cat_a, 200, BIG, "idle1");
        expect_frame(256, 8'hFF, cat_a, 438, BIG, "a");
        expect_frame(384, 8'hFF, cat_a, 438, BIG, "a_hold");
        send(200, 32'h76543210, 8'h01, 8'hFF);

        // Mid-frame accept in digit 3, then two ignored requests while pending.
        expect_frame(512, 8'hFF, cat_b, 640, BIG, "b");
        send(438, 32'hFEDCBA98, 8'h80, 8'hFF);
        send(450, 32'h11111111, 8'hFF, 8'hFF);
        send(470, 32'h22222222, 8'h00, 8'h0F);

        expect_frame(640, 8'hFF, cat_b, 640, BIG, "b_hold");
        expect_frame(768, 8'h0A, cat_c, 895, BIG, "c");
        expect_frame(896, 8'h0A, cat_c, 895, BIG, "c_hold");
        send(640, 32'h76543210, 8'h00, 8'h0A);

        // Accepted in the end-of-frame cycle: lands one frame later.
        expect_frame(1024, 8'hA0, cat_d, 1152, BIG, "d");
        expect_frame(1152, 8'hA0, cat_d, 1152, 1240, "d_cut");
        send(895, 32'h76543210, 8'h80, 8'hA0);
        send(1152, 32'h88888888, 8'hFF, 8'hFF);

        while (pos != 1240) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_anodes", 32'(anodes), 32'hFF);
        chk("midrst_cathodes", 32'(cathodes), 32'hFF);
        chk("midrst_ready", 32'(upd_ready), 32'd1);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        expect_frame(0,   8'h00, cat_d, BIG, BIG, "post_rst0");
        expect_frame(128, 8'h00, cat_d, BIG, BIG, "post_rst1");

        for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter DIGIT_CYCLES, default 262144, sets clk cycles per digit slot; legal range 8..2^24.
REQ-002 Parameter BLANK_CYCLES, default 1024, sets the anti-ghost blank cycles at the start of each slot; constraint 1 <= BLANK_CYCLES < DIGIT_CYCLES.
REQ-003 Port list, one per line, clock and reset first:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- upd_valid  in  1  update request
- upd_ready  out  1  controller can accept an update
- upd_hex  in  32  8 hex nibbles; nibble k drives digit k
- upd_dp  in  8  decimal-point on, per digit, active-high
- upd_en  in  8  digit enable, active-high
- anodes  out  8  An7..An0, active-low
- cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
- frame_done  out  1  one-cycle pulse at end of frame

Function
REQ-004 Internal state: slot counter cnt (0..DIGIT_CYCLES-1), digit index idx (0..7), active set {hex, dp, en}, shadow set, pending flag.
REQ-005 Phase: BLANK while cnt < BLANK_CYCLES; DRIVE otherwise; two phases only, no other states.
REQ-006 cnt increments every cycle; at DIGIT_CYCLES-1 it wraps to 0 and idx increments; idx wraps 7 -> 0.
REQ-007 Outputs are registered; they reflect the phase/idx of the cycle after the edge that produced them (one-cycle latency, fixed).
REQ-008 BLANK: anodes = 8'hFF, cathodes = 8'hFF.
REQ-009 DRIVE with en[idx]=1: anodes bit idx = 0, others 1; cathodes = decode(hex nibble idx) with Dp = ~dp[idx].
REQ-010 DRIVE with en[idx]=0: anodes = 8'hFF, cathodes = 8'hFF.
REQ-011 Decode, abcdefg active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
REQ-012 Handshake: update accepted on the edge where upd_valid and upd_ready are both 1; inputs are copied to the shadow set, pending set, upd_ready falls.
REQ-013 upd_valid while upd_ready=0 is ignored; no data captured, no error.
REQ-014 End of frame is the cycle with idx=7 and cnt=DIGIT_CYCLES-1; frame_done is 1 during exactly that cycle.
REQ-015 At the end-of-frame edge, if pending: shadow -> active, pending cleared, upd_ready = 1 on the next cycle; display never changes mid-frame.
REQ-016 upd_ready is 0 only while pending, so accept and commit can never coincide.
REQ-017 An update accepted during the end-of-frame cycle itself is committed at the end of the following frame.
REQ-018 At most one anode is low in any cycle; no two digits ever drive in consecutive cycles without at least BLANK_CYCLES of all-high between them.

Reset
REQ-019 Reset asserted: cnt=0, idx=0, active and shadow sets all zero (all digits disabled), pending=0.
REQ-020 Reset asserted: anodes=8'hFF, cathodes=8'hFF, upd_ready=1, frame_done=0, taking effect immediately without a clock edge.
REQ-021 Reset mid-slot or mid-handshake discards pending data; after release the scan restarts in BLANK of digit 0.

Structure
REQ-022 Shared package holds NUM_DIGITS=8, the 16-entry segment table constants, BLANK_PATTERN=8'hFF, and the default DIGIT_CYCLES/BLANK_CYCLES.
REQ-023 One combinational sub-module hex_to_seg (4-bit in, 7-bit active-low out) implements REQ-011; all sequential logic stays in ssd_scan_ctrl.

Verification (DIGIT_CYCLES=16, BLANK_CYCLES=4)
REQ-024 Reset, then clock 200 cycles with no update -> anodes=FF, cathodes=FF throughout, upd_ready=1, frame_done pulses every 128 cycles.
REQ-025 Send hex=0x76543210, en=FF, dp=0x01, then wait one frame -> in the next frame, each slot shows 4 cycles FF/FF then 12 cycles of anode k low; digit 0 cathodes=0x02, digit 7 cathodes=0x1F.
REQ-026 Send an update mid-frame (idx=3) -> upd_ready=0 until end-of-frame; active digits 4..7 unchanged in that frame; new values appear from digit 0 of the next frame.
REQ-027 Pulse upd_valid twice while pending with different data -> only the first value is displayed; the second is never seen.
REQ-028 Send en=0x0A -> only anodes bits 1 and 3 ever go low; all other slots show FF/FF.
REQ-029 Assert reset during DRIVE of digit 5 with an update pending -> outputs go FF/FF immediately; after release, digit 0 starts in BLANK, display stays blank, and upd_ready=1.
